// File: rtl/dpll_pkg.sv
// dpll_pkg
//   Shared definitions for the DPLL trim controller: default widths, the
//   loop-controller state encoding and the Gray-to-binary helper.
package dpll_pkg;

  localparam int DPLL_TRIM_W = 26;
  localparam int DPLL_CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_FILL  = 2'd2,
    ST_TRACK = 2'd3
  } dpll_state_e;

  // Works on a 32-bit container: narrower Gray codes are zero-extended,
  // and leading zeros do not disturb the prefix-XOR of the lower bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/dpll_therm_encoder.sv
// dpll_therm_encoder
//   Combinational level -> thermometer code, LSB first.
//   level : number of ones to emit (0..TRIM_W)
//   code  : code[i] = 1 for i < level
module dpll_therm_encoder
  import dpll_pkg::*;
#(
  parameter int TRIM_W = DPLL_TRIM_W
) (
  input  logic [4:0]        level,
  output logic [TRIM_W-1:0] code
);

  always_comb begin
    code = '0;
    for (int i = 0; i < TRIM_W; i++) begin
      code[i] = (level > 5'(i));
    end
  end

endmodule

// File: rtl/dpll_trim_controller.sv
// dpll_trim_controller
//   Frequency-locking loop in front of the DCO. Measures DCO cycles per
//   reference period from a synchronised Gray edge counter, compares the
//   two-period sum against 2*div and steps a thermometer trim code.
//   osc        : reference clock
//   reset      : synchronous, active-high
//   enable     : loop enable
//   dco        : bypass, trim follows ext_trim
//   div        : target DCO/osc ratio
//   ext_trim   : manual trim code
//   cnt_gray   : Gray DCO edge count, already in the osc domain
//   trim       : registered trim code to the DCO
//   trim_level : current thermometer level
//   locked     : frequency lock indicator
//
// state    | meaning
// ST_IDLE  | loop off (disabled, bypassed or just reset)
// ST_PRIME | capture first counter sample
// ST_FILL  | capture first delta
// ST_TRACK | measure every cycle, adjust/evaluate every second cycle
module dpll_trim_controller
  import dpll_pkg::*;
#(
  parameter int CNT_W    = DPLL_CNT_W,
  parameter int TRIM_W   = DPLL_TRIM_W,
  parameter int HYST     = 1,
  parameter int LOCK_CNT = 8
) (
  input  logic              osc,
  input  logic              reset,
  input  logic              enable,
  input  logic              dco,
  input  logic [4:0]        div,
  input  logic [TRIM_W-1:0] ext_trim,
  input  logic [CNT_W-1:0]  cnt_gray,
  output logic [TRIM_W-1:0] trim,
  output logic [4:0]        trim_level,
  output logic              locked
);

  localparam int SW   = CNT_W + 1;
  localparam int LC_W = $clog2(LOCK_CNT + 1);

  localparam logic [4:0]      LEVEL_MAX = 5'(TRIM_W);
  localparam logic [LC_W-1:0] LOCK_MAX  = LC_W'(LOCK_CNT);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CNT - 1);
  localparam logic [SW-1:0]   HYST_V    = SW'(HYST);

  dpll_state_e       state;
  logic [CNT_W-1:0]  bin_prev;
  logic [CNT_W-1:0]  delta_prev;
  logic [LC_W-1:0]   lock_ctr;
  logic              phase;

  logic [CNT_W-1:0]  bin;
  logic [CNT_W-1:0]  delta;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     target;
  logic [SW-1:0]     band_hi;
  logic [SW-1:0]     band_lo;
  logic [TRIM_W-1:0] therm_code;

  assign bin    = CNT_W'(gray2bin(32'(cnt_gray)));
  // Modular subtraction absorbs counter wrap.
  assign delta  = bin - bin_prev;
  assign sum    = SW'(delta) + SW'(delta_prev);
  assign target = SW'({div, 1'b0});
  assign band_hi = target + HYST_V;
  // Lower bound clamps at zero rather than going negative.
  assign band_lo = (target >= HYST_V) ? (target - HYST_V) : '0;

  dpll_therm_encoder #(
    .TRIM_W (TRIM_W)
  ) u_therm (
    .level (trim_level),
    .code  (therm_code)
  );

  always_ff @(posedge osc) begin
    if (reset) begin
      state      <= ST_IDLE;
      bin_prev   <= '0;
      delta_prev <= '0;
      lock_ctr   <= '0;
      phase      <= 1'b0;
      trim_level <= '0;
      trim       <= '0;
      locked     <= 1'b0;
    end else begin
      trim <= dco ? ext_trim : therm_code;

      if (!enable || dco) begin
        // trim_level is kept so a re-enable resumes from the old code.
        state    <= ST_IDLE;
        lock_ctr <= '0;
        locked   <= 1'b0;
        phase    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_PRIME;
          end
          ST_PRIME: begin
            bin_prev <= bin;
            state    <= ST_FILL;
          end
          ST_FILL: begin
            bin_prev   <= bin;
            delta_prev <= delta;
            state      <= ST_TRACK;
          end
          ST_TRACK: begin
            bin_prev   <= bin;
            delta_prev <= delta;
            phase      <= ~phase;
            if (div == 5'd0) begin
              lock_ctr <= '0;
              locked   <= 1'b0;
            end else if (phase) begin
              if (sum > band_hi) begin
                if (trim_level != LEVEL_MAX) trim_level <= trim_level + 5'd1;
                lock_ctr <= '0;
                locked   <= 1'b0;
              end else if (sum < band_lo) begin
                if (trim_level != 5'd0) trim_level <= trim_level - 5'd1;
                lock_ctr <= '0;
                locked   <= 1'b0;
              end else begin
                if (lock_ctr != LOCK_MAX) lock_ctr <= lock_ctr + 1'b1;
                if (lock_ctr >= LOCK_LAST) locked <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpll_trim_controller.sv
// tb_dpll_trim_controller
//   Directed and randomized stimulus for dpll_trim_controller, checked each
//   cycle against a behavioural model built from the loop's rules: sum of the
//   last two per-period counter advances vs a dead band around 2*div.
module tb_dpll_trim_controller;

  localparam int HYST = 1;

  logic        osc = 1'b0;
  logic        reset;
  logic        enable;
  logic        dco;
  logic [4:0]  div;
  logic [25:0] ext_trim;
  logic [6:0]  cnt_gray;
  logic [25:0] trim;
  logic [4:0]  trim_level;
  logic        locked;

  int total = 0;
  int bad   = 0;

  // model state
  int          cur_bin;
  int          h1 = 0;
  int          h2 = 0;
  int          m_level = 0;
  int          m_inrun = 0;
  int          m_run = 0;
  bit          m_locked = 1'b0;
  logic [25:0] m_trim = '0;

  always #5 osc = ~osc;

  dpll_trim_controller dut (
    .osc        (osc),
    .reset      (reset),
    .enable     (enable),
    .dco        (dco),
    .div        (div),
    .ext_trim   (ext_trim),
    .cnt_gray   (cnt_gray),
    .trim       (trim),
    .trim_level (trim_level),
    .locked     (locked)
  );

  function automatic logic [25:0] therm(input int l);
    logic [63:0] x;
    x = (64'd1 << l) - 64'd1;
    return x[25:0];
  endfunction

  function automatic logic [6:0] to_gray(input int b);
    logic [6:0] v;
    v = 7'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int mod128(input int x);
    return ((x % 128) + 128) % 128;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One osc edge: update model from the inputs seen at the edge, then check.
  task automatic cycle();
    int b0, sum, hi, lo;
    @(posedge osc);
    b0 = cur_bin;
    if (reset) begin
      m_level  = 0;
      m_locked = 1'b0;
      m_trim   = '0;
      m_run    = 0;
      m_inrun  = 0;
    end else begin
      m_trim = dco ? ext_trim : therm(m_level);
      if (enable && !dco) begin
        // m_run = active edges before this one; 3+ means tracking
        if (m_run >= 3) begin
          if (div == 5'd0) begin
            m_inrun  = 0;
            m_locked = 1'b0;
          end else if ((m_run - 3) % 2 == 1) begin
            sum = mod128(b0 - h1) + mod128(h1 - h2);
            hi  = 2 * int'(div) + HYST;
            lo  = 2 * int'(div) - HYST;
            if (lo < 0) lo = 0;
            if (sum > hi) begin
              if (m_level < 26) m_level++;
              m_inrun  = 0;
              m_locked = 1'b0;
            end else if (sum < lo) begin
              if (m_level > 0) m_level--;
              m_inrun  = 0;
              m_locked = 1'b0;
            end else begin
              if (m_inrun < 8) m_inrun++;
              if (m_inrun == 8) m_locked = 1'b1;
            end
          end
        end
        m_run++;
      end else begin
        m_run    = 0;
        m_inrun  = 0;
        m_locked = 1'b0;
      end
    end
    h2 = h1;
    h1 = b0;
    #1;
    chk("trim", 32'(trim), 32'(m_trim));
    chk("trim_level", 32'(trim_level), 32'(m_level));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic adv(input int n);
    cur_bin  = mod128(cur_bin + n);
    cnt_gray = to_gray(cur_bin);
    cycle();
  endtask

  initial begin
    int guard;
    int a;
    bit alt;

    reset    = 1'b1;
    enable   = 1'b1;
    dco      = 1'b0;
    div      = 5'd8;
    ext_trim = '0;
    cur_bin  = 0;
    cnt_gray = to_gray(0);

    // reset held 3 cycles with the counter moving
    for (int i = 0; i < 3; i++) adv(int'($urandom_range(1, 20)));
    chk("rst_trim", 32'(trim), 32'h0);
    chk("rst_level", 32'(trim_level), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);

    // too fast: 12 per cycle
    reset = 1'b0;
    for (int i = 0; i < 64; i++) adv(12);
    chk("fast_sat_level", 32'(trim_level), 32'd26);
    chk("fast_sat_trim", 32'(trim), 32'h3FFFFFF);
    chk("fast_locked", 32'(locked), 32'h0);

    // too slow across counter wrap, restarted from bin=120
    enable = 1'b0;
    adv(5);
    enable   = 1'b1;
    cur_bin  = 120;
    cnt_gray = to_gray(cur_bin);
    cycle();
    for (int i = 0; i < 64; i++) adv(5);
    chk("slow_floor_level", 32'(trim_level), 32'd0);
    chk("slow_floor_trim", 32'(trim), 32'h0);

    // lock: alternating 8/9 gives sum 17, inside 15..17
    alt = 1'($urandom_range(0, 1));
    for (int i = 0; i < 24; i++) begin
      adv(alt ? 9 : 8);
      alt = ~alt;
    end
    chk("lock_up", 32'(locked), 32'h1);
    adv(12);
    for (int i = 0; i < 2; i++) begin
      adv(alt ? 9 : 8);
      alt = ~alt;
    end
    chk("lock_lost", 32'(locked), 32'h0);

    // climb to level 10, then bypass
    guard = 0;
    while (m_level != 10 && guard < 200) begin
      adv(m_level < 10 ? 12 : 5);
      guard++;
    end
    chk("reach_level10", 32'(trim_level), 32'd10);
    dco      = 1'b1;
    ext_trim = 26'h155;
    adv(12);
    chk("byp_trim", 32'(trim), 32'h155);
    chk("byp_locked", 32'(locked), 32'h0);
    chk("byp_level", 32'(trim_level), 32'd10);
    for (int i = 0; i < 4; i++) begin
      ext_trim = 26'($urandom);
      adv(int'($urandom_range(0, 30)));
    end
    chk("byp_hold_level", 32'(trim_level), 32'd10);
    dco = 1'b0;
    for (int i = 0; i < 12; i++) begin
      adv(alt ? 9 : 8);
      alt = ~alt;
    end
    chk("byp_return_trim", 32'(trim), 32'h3FF);

    // down to 7, then a one-cycle disable
    guard = 0;
    while (m_level != 7 && guard < 200) begin
      adv(m_level > 7 ? 5 : 12);
      guard++;
    end
    chk("reach_level7", 32'(trim_level), 32'd7);
    enable = 1'b0;
    adv(5);
    chk("dis_locked", 32'(locked), 32'h0);
    chk("dis_trim", 32'(trim), 32'h7F);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) adv(12);
    chk("reen_no_adjust", 32'(trim_level), 32'd7);
    adv(12);
    chk("reen_first_step", 32'(trim_level), 32'd8);

    // div = 0 while tracking: no steps, no lock
    div = 5'd0;
    for (int i = 0; i < 8; i++) adv(int'($urandom_range(0, 20)));
    chk("div0_level", 32'(trim_level), 32'd8);
    chk("div0_locked", 32'(locked), 32'h0);

    // randomized operation
    div = 5'd8;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) dco = ~dco;
      if ($urandom_range(0, 31) == 0) div = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 7) == 0) ext_trim = 26'($urandom);
      a = (int'(div) > 2 ? int'(div) - 2 : 0) + int'($urandom_range(0, 4));
      adv(a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpll_trim_controller.md
Name: dpll_trim_controller

Overview:
- Frequency-locking loop controller that sits directly upstream of the DCO in digital_pll and drives its 26-bit trim code.
- Clocked by the reference oscillator.
- Each reference cycle it reads a Gray-coded DCO edge count, already synchronised into the reference domain, and computes DCO cycles per reference period.
- It compares that rate with div and steps a thermometer trim code up or down until the DCO runs at div × f_osc.
- In dco bypass mode it passes ext_trim straight through.

Parameters:
- CNT_W, 7, width of the incoming DCO edge counter; 2*div_max + HYST must be < 2^CNT_W.
- TRIM_W, 26, number of DCO trim bits, which is also the maximum trim level.
- HYST, 1, half-width of the dead band on the two-period sum, in DCO cycles.
- LOCK_CNT, 8, consecutive in-band evaluations required before locked asserts.

Ports:
- osc, input, 1: reference clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: loop enable.
- dco, input, 1: bypass/manual mode; 1 selects ext_trim as the trim source.
- div, input, 5: target DCO/osc frequency ratio.
- ext_trim, input, TRIM_W: manual trim code.
- cnt_gray, input, CNT_W: Gray-coded free-running DCO edge counter, already 2-flop synchronised to osc.
- trim, output, TRIM_W: registered trim code to the DCO.
- trim_level, output, 5: current thermometer level, 0..TRIM_W.
- locked, output, 1: frequency-lock indicator.

Behaviour:
- Reset values: trim=0, trim_level=0, locked=0, state=IDLE, bin_prev=0, delta_prev=0, lock_ctr=0, phase=0.
- bin is the combinational Gray-to-binary conversion of cnt_gray.
- delta = (bin - bin_prev) mod 2^CNT_W. Counter wrap is absorbed by the modular subtraction.
- sum = delta + delta_prev, computed CNT_W+1 bits wide.
- target = {div,1'b0}, i.e. 2*div, computed CNT_W+1 bits wide.
- FSM, evaluated every osc edge:
  - IDLE: entered on reset, enable=0, or dco=1. Goes to PRIME when enable=1 and dco=0.
  - PRIME: bin_prev<=bin. Goes to FILL.
  - FILL: bin_prev<=bin, delta_prev<=delta. Goes to TRACK.
  - TRACK: bin_prev<=bin, delta_prev<=delta, and phase toggles every cycle.
- Adjustment in TRACK happens only on cycles where phase=1, so there is at most one step per 2 osc cycles to let the DCO settle:
  - sum > target+HYST (too fast): trim_level+1, saturating at TRIM_W.
  - sum < target-HYST, computed signed, treating a negative bound as 0 (too slow): trim_level-1, saturating at 0.
  - Otherwise (in band): level held and lock_ctr+1, saturating at LOCK_CNT.
  - Any out-of-band evaluation clears lock_ctr and locked in that same edge.
- locked <= 1 on the edge where lock_ctr reaches LOCK_CNT. It is cleared whenever the state is not TRACK.
- div=0 in TRACK: no adjustment, lock_ctr cleared, locked=0.
- Trim output:
  - dco=0: trim registered from trim_level as a thermometer code, trim[i]=1 for i<trim_level, LSB-first.
  - dco=1: trim<=ext_trim (registered, 1-cycle latency). trim_level is held.
- Leaving TRACK: enable falling, or dco rising, mid-operation sends the FSM to IDLE next edge and clears locked. trim_level is retained, so re-enable resumes from the previous code. The full PRIME/FILL sequence reruns before any adjustment.
- Latency from a cnt_gray change to a trim change is at most 2 osc cycles in TRACK.
- reset dominates enable and dco on the same edge.

Decomposition:
- Shared package dpll_pkg holds:
  - TRIM_W=26 and the default CNT_W;
  - the state encoding IDLE/PRIME/FILL/TRACK;
  - the gray2bin function.
- One sub-module, dpll_therm_encoder: combinational, level (5b) -> TRIM_W thermometer code. It is instanced once and registered in the parent.

Test Plan:
- Reset: hold reset 3 cycles with enable=1 and cnt_gray toggling -> trim=0, trim_level=0, locked=0; FSM goes IDLE->PRIME->FILL->TRACK starting the first cycle after release.
- Too fast: div=8, bin advances 12 per cycle (sum=24 > 17) -> trim_level increments once every 2 cycles, saturates at 26 with trim=26'h3FFFFFF, locked stays 0.
- Too slow, plus wrap: div=8, advance 5 per cycle starting from bin=120 so the counter wraps at 128 -> deltas stay 5, trim_level decrements to 0 with no spurious step at the wrap.
- Lock: div=8, advance alternating 8/9 (sum=17, in band) -> trim_level constant; locked rises on the 8th in-band evaluation (16 cycles after entering TRACK). One cycle with advance 12 then clears locked on that evaluation.
- Bypass: in TRACK with trim_level=10, set dco=1 with ext_trim=26'h155 -> trim=26'h155 one cycle later, locked=0, trim_level stays 10. Clearing dco returns trim to 26'h3FF after PRIME/FILL.
- Mid-operation disable: drop enable for 1 cycle at trim_level=7 -> state IDLE, locked=0, trim=26'h7F held; after re-enable, no adjustment occurs until the 2nd TRACK cycle.
